// File: rtl/axis_fifo_buffer_if.sv
// axis_fifo_buffer_if: AXI4-Stream beat bundle (tdata/tvalid/tready/tlast/tuser) with master/slave views.
interface axis_fifo_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_fifo_buffer.sv
// axis_fifo_buffer: DEPTH-entry first-word-fall-through AXIS FIFO carrying tdata/tlast/tuser.
// Define AXIS_FIFO_PKT_CNT_EN to add the pkt_count port (complete packets stored).
module axis_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  axis_fifo_buffer_if.slave       s_axis,
  axis_fifo_buffer_if.master      m_axis,
  output logic [$clog2(DEPTH):0]  occupancy
`ifdef AXIS_FIFO_PKT_CNT_EN
  ,
  output logic [$clog2(DEPTH):0]  pkt_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = DATA_WIDTH + USER_WIDTH + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         push, pop, full, empty;
  logic [W-1:0] head;
  always_comb begin
    full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty         = wr_ptr_q == rd_ptr_q;
    occupancy     = wr_ptr_q - rd_ptr_q;
    s_axis.tready = !reset && !full;
    m_axis.tvalid = !empty;
    push          = s_axis.tvalid && s_axis.tready;
    pop           = m_axis.tvalid && m_axis.tready;
    head          = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    {m_axis.tdata, m_axis.tuser, m_axis.tlast} = head;
    wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Storage is deliberately unreset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tdata, s_axis.tuser, s_axis.tlast};
  end
`ifdef AXIS_FIFO_PKT_CNT_EN
  logic [AW:0] pkt_q, pkt_d;
  always_comb begin
    pkt_d     = pkt_q + {{AW{1'b0}}, push && s_axis.tlast} - {{AW{1'b0}}, pop && m_axis.tlast};
    pkt_count = pkt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) pkt_q <= '0;
    else pkt_q <= pkt_d;
  end
`endif
endmodule

// File: tb/tb_axis_fifo_buffer.sv
// tb_axis_fifo_buffer: directed vector table plus streaming, random-scoreboard and reset sequences.
module tb_axis_fifo_buffer;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] occupancy;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  axis_fifo_buffer_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s_if ();
  axis_fifo_buffer_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m_if ();
`ifdef AXIS_FIFO_PKT_CNT_EN
  logic [2:0] pkt_count;
`endif
  axis_fifo_buffer #(.DATA_WIDTH(8), .USER_WIDTH(1), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .s_axis(s_if.slave),
    .m_axis(m_if.master),
    .occupancy(occupancy)
`ifdef AXIS_FIFO_PKT_CNT_EN
    ,
    .pkt_count(pkt_count)
`endif
  );
  typedef struct {
    logic       rst, sv;
    logic [7:0] d;
    logic       l, u, mr;
    logic       rdy, v;
    logic [7:0] md;
    logic       ml, mu;
    logic [2:0] occ;
  } vec_t;
  vec_t vecs [13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic sv, input logic [7:0] d, input logic l, input logic u, input logic mr);
    reset = r;
    s_if.tvalid = sv;
    s_if.tdata = d;
    s_if.tlast = l;
    s_if.tuser = u;
    m_if.tready = mr;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [9:0] q [$];
    logic [9:0] prev_beat;
    logic       prev_stall;
    int         pushed;
    int         cyc;
    vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 3'd0};
    vecs[1]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 3'd0};
    vecs[2]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 3'd0};
    vecs[3]  = '{0, 1, 8'h11, 0, 1, 0, 1, 0, 8'h00, 0, 0, 3'd0};
    vecs[4]  = '{0, 1, 8'h22, 0, 0, 0, 1, 1, 8'h11, 0, 1, 3'd1};
    vecs[5]  = '{0, 1, 8'h33, 1, 1, 0, 1, 1, 8'h11, 0, 1, 3'd2};
    vecs[6]  = '{0, 1, 8'h44, 0, 0, 0, 1, 1, 8'h11, 0, 1, 3'd3};
    vecs[7]  = '{0, 1, 8'h55, 1, 1, 0, 0, 1, 8'h11, 0, 1, 3'd4};
    vecs[8]  = '{0, 1, 8'h55, 1, 1, 1, 0, 1, 8'h11, 0, 1, 3'd4};
    vecs[9]  = '{0, 0, 8'h00, 0, 0, 1, 1, 1, 8'h22, 0, 0, 3'd3};
    vecs[10] = '{0, 0, 8'h00, 0, 0, 1, 1, 1, 8'h33, 1, 1, 3'd2};
    vecs[11] = '{0, 0, 8'h00, 0, 0, 1, 1, 1, 8'h44, 0, 0, 3'd1};
    vecs[12] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 3'd0};
    drive(1, 0, 8'h00, 0, 0, 0);
    tick();
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].d, vecs[i].l, vecs[i].u, vecs[i].mr);
      #1;
      chk($sformatf("vec%0d s_tready", i), 32'(s_if.tready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d m_tvalid", i), 32'(m_if.tvalid), 32'(vecs[i].v));
      chk($sformatf("vec%0d m_tdata", i), 32'(m_if.tdata), 32'(vecs[i].md));
      chk($sformatf("vec%0d m_tlast", i), 32'(m_if.tlast), 32'(vecs[i].ml));
      chk($sformatf("vec%0d m_tuser", i), 32'(m_if.tuser), 32'(vecs[i].mu));
      chk($sformatf("vec%0d occupancy", i), 32'(occupancy), 32'(vecs[i].occ));
      tick();
    end
    // Continuous flow: one beat per cycle, occupancy pinned at 1, pointers wrap several times.
    for (int i = 0; i < 21; i++) begin
      drive(0, 1, 8'(8'h80 + i), 0, 0, 1);
      #1;
      if (i > 0) begin
        chk("stream occupancy", 32'(occupancy), 32'd1);
        chk("stream m_tdata", 32'(m_if.tdata), 32'(8'(8'h80 + i - 1)));
        chk("stream s_tready", 32'(s_if.tready), 32'd1);
      end
      tick();
    end
    drive(0, 0, 8'h00, 0, 0, 1);
    tick();
    chk("stream drained", 32'(occupancy), 32'd0);
    // Random handshakes against a queue scoreboard.
    pushed = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_beat = '0;
    while (pushed < 1000 && cyc < 20000) begin
      logic sv, mr, push, pop;
      sv = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      drive(0, sv, pushed[7:0], (pushed % 5) == 4, pushed[0], mr);
      #1;
      chk("rand s_tready", 32'(s_if.tready), 32'(q.size() != 4));
      chk("rand m_tvalid", 32'(m_if.tvalid), 32'(q.size() != 0));
      chk("rand occupancy", 32'(occupancy), 32'(q.size()));
      if (q.size() != 0) chk("rand head", 32'({m_if.tdata, m_if.tuser, m_if.tlast}), 32'(q[0]));
      if (prev_stall) begin
        chk("rand stall valid", 32'(m_if.tvalid), 32'd1);
        chk("rand stall beat", 32'({m_if.tdata, m_if.tuser, m_if.tlast}), 32'(prev_beat));
      end
      push = sv && (q.size() != 4);
      pop = mr && (q.size() != 0);
      prev_stall = (q.size() != 0) && !mr;
      prev_beat = {m_if.tdata, m_if.tuser, m_if.tlast};
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back({pushed[7:0], pushed[0], 1'((pushed % 5) == 4)});
        pushed++;
      end
      cyc++;
      tick();
    end
    chk("rand beat budget", 32'(pushed >= 1000), 32'd1);
    drive(1, 0, 8'h00, 0, 0, 0);
    tick();
    // Two 2-beat packets, partial drain, then reset with beats still stored.
    drive(0, 1, 8'hb1, 0, 0, 0);
    tick();
    drive(0, 1, 8'hb2, 1, 1, 0);
    tick();
    drive(0, 1, 8'hb3, 0, 0, 0);
    tick();
    drive(0, 1, 8'hb4, 1, 1, 0);
    tick();
    drive(0, 0, 8'h00, 0, 0, 0);
    #1;
    chk("pkt full occupancy", 32'(occupancy), 32'd4);
    chk("pkt full s_tready", 32'(s_if.tready), 32'd0);
`ifdef AXIS_FIFO_PKT_CNT_EN
    chk("pkt_count two", 32'(pkt_count), 32'd2);
`endif
    drive(0, 0, 8'h00, 0, 0, 1);
    tick();
    tick();
    drive(0, 0, 8'h00, 0, 0, 0);
    #1;
    chk("pkt drain occupancy", 32'(occupancy), 32'd2);
    chk("pkt drain head", 32'(m_if.tdata), 32'hb3);
`ifdef AXIS_FIFO_PKT_CNT_EN
    chk("pkt_count one", 32'(pkt_count), 32'd1);
`endif
    drive(1, 1, 8'hee, 1, 1, 1);
    #1;
    chk("reset s_tready low", 32'(s_if.tready), 32'd0);
    tick();
    drive(0, 0, 8'h00, 0, 0, 0);
    #1;
    chk("post-reset occupancy", 32'(occupancy), 32'd0);
    chk("post-reset m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("post-reset m_tdata", 32'(m_if.tdata), 32'd0);
    chk("post-reset s_tready", 32'(s_if.tready), 32'd1);
`ifdef AXIS_FIFO_PKT_CNT_EN
    chk("pkt_count reset", 32'(pkt_count), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
